// File: rtl/icache_pkg.sv
// Shared defaults and types for the banked I-cache overhead (valid+tag) store.
package icache_pkg;

    localparam int ICACHE_LNUM = 256;
    localparam int ICACHE_NWAY = 2;
    localparam int ICACHE_TAGW = 20;

    typedef struct packed {
        logic                   valid;
        logic [ICACHE_TAGW-1:0] tag;
    } ohd_entry_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } clr_state_t;

endpackage

// File: rtl/icache_ohd_bank.sv
// One overhead bank: ROWS rows of NWAY {valid,tag} entries, registered read port,
// per-way write enables and a whole-row clear used by the invalidate sweep.
module icache_ohd_bank #(
    parameter  int ROWS = 128,
    parameter  int NWAY = 2,
    parameter  int ENTW = 21,
    localparam int ROWW = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_en_i,
    input  logic [ROWW-1:0]      wr_row_i,
    input  logic [NWAY-1:0]      wr_way_en_i,
    input  logic [ENTW-1:0]      wr_data_i,
    input  logic                 rd_en_i,
    input  logic [ROWW-1:0]      rd_row_i,
    output logic [NWAY*ENTW-1:0] rd_data_o
);

    // NOTE: the array has no reset so it can map onto block RAM; the clear sweep initialises it.
    logic [NWAY*ENTW-1:0] mem_q [ROWS];
    logic [NWAY*ENTW-1:0] rd_data_q;

    // NOTE: non-blocking writes make a same-row read return the pre-write contents.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NWAY; w++) begin
            if (clr_en_i || wr_way_en_i[w]) begin
                mem_q[wr_row_i][w*ENTW +: ENTW] <= clr_en_i ? '0 : wr_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_row_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/icache_overhead_banked.sv
// Even/odd banked I-cache overhead store: dual-line lookup (wrapping pair),
// single-line refill writes with write-first forwarding, and an invalidate sweep.
module icache_overhead_banked
    import icache_pkg::*;
#(
    parameter  int LNUM   = ICACHE_LNUM,
    parameter  int NWAY   = ICACHE_NWAY,
    parameter  int TAGW   = ICACHE_TAGW,
    localparam int LADDRW = $clog2(LNUM),
    localparam int WAYW   = (NWAY > 1) ? $clog2(NWAY) : 1,
    localparam int ENTW   = 1 + TAGW,
    localparam int OHDW   = NWAY * ENTW
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              flush,
    input  logic              re,
    input  logic [LADDRW-1:0] rd_laddr,
    input  logic [TAGW-1:0]   rd_tag0,
    input  logic [TAGW-1:0]   rd_tag1,
    output logic              rd_valid,
    output logic [OHDW-1:0]   rd_ohd0,
    output logic [OHDW-1:0]   rd_ohd1,
    output logic [NWAY-1:0]   hit0,
    output logic [NWAY-1:0]   hit1,
    input  logic              we,
    input  logic [LADDRW-1:0] wr_laddr,
    input  logic [WAYW-1:0]   wr_way,
    input  logic [ENTW-1:0]   wr_ohd
);

    localparam int ROWS = LNUM / 2;
    localparam int ROWW = LADDRW - 1;
    localparam logic [ROWW-1:0] LAST_ROW = ROWW'(ROWS - 1);

    clr_state_t      state_q, state_d;
    logic [ROWW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ROW) state_d = RUN;
            end
            RUN: begin
                if (flush) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    logic clearing, re_ok, we_ok;
    assign clearing = (state_q == CLEAR);
    assign ready    = (state_q == RUN);
    assign re_ok    = re & ready & ~flush;
    assign we_ok    = we & ready & ~flush;

    logic [ROWW-1:0]   rd_row, rd_row_inc, wr_row, bank_wr_row;
    logic [LADDRW-1:0] rd_laddr1;
    logic [NWAY-1:0]   way_hot;

    assign rd_row      = rd_laddr[LADDRW-1:1];
    assign rd_row_inc  = rd_row + 1'b1;
    assign rd_laddr1   = rd_laddr + 1'b1;
    assign wr_row      = wr_laddr[LADDRW-1:1];
    assign bank_wr_row = clearing ? cnt_q : wr_row;

    always_comb begin
        way_hot = '0;
        for (int w = 0; w < NWAY; w++) begin
            if (wr_way == WAYW'(w)) way_hot[w] = 1'b1;
        end
    end

    logic [OHDW-1:0] e_data, o_data;

    // An odd first line pairs with the next row of the even bank (wrapping to row 0).
    icache_ohd_bank #(.ROWS(ROWS), .NWAY(NWAY), .ENTW(ENTW)) u_bank_e (
        .clk        (clk),
        .rst        (rst),
        .clr_en_i   (clearing),
        .wr_row_i   (bank_wr_row),
        .wr_way_en_i((we_ok && !wr_laddr[0]) ? way_hot : '0),
        .wr_data_i  (wr_ohd),
        .rd_en_i    (re_ok),
        .rd_row_i   (rd_laddr[0] ? rd_row_inc : rd_row),
        .rd_data_o  (e_data)
    );

    icache_ohd_bank #(.ROWS(ROWS), .NWAY(NWAY), .ENTW(ENTW)) u_bank_o (
        .clk        (clk),
        .rst        (rst),
        .clr_en_i   (clearing),
        .wr_row_i   (bank_wr_row),
        .wr_way_en_i((we_ok && wr_laddr[0]) ? way_hot : '0),
        .wr_data_i  (wr_ohd),
        .rd_en_i    (re_ok),
        .rd_row_i   (rd_row),
        .rd_data_o  (o_data)
    );

    logic            sel_q, rd_valid_q;
    logic [TAGW-1:0] tag0_q, tag1_q;
    logic [NWAY-1:0] fwd0_q, fwd1_q;
    logic [ENTW-1:0] fwd_ohd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            sel_q      <= 1'b0;
            tag0_q     <= '0;
            tag1_q     <= '0;
            fwd0_q     <= '0;
            fwd1_q     <= '0;
            fwd_ohd_q  <= '0;
        end else begin
            rd_valid_q <= re_ok;
            if (re_ok) begin
                sel_q     <= rd_laddr[0];
                tag0_q    <= rd_tag0;
                tag1_q    <= rd_tag1;
                fwd0_q    <= (we_ok && wr_laddr == rd_laddr)  ? way_hot : '0;
                fwd1_q    <= (we_ok && wr_laddr == rd_laddr1) ? way_hot : '0;
                fwd_ohd_q <= wr_ohd;
            end
        end
    end

    assign rd_valid = rd_valid_q;

    // Same-cycle writes override the read-first bank data for the matching way.
    always_comb begin
        rd_ohd0 = sel_q ? o_data : e_data;
        rd_ohd1 = sel_q ? e_data : o_data;
        hit0    = '0;
        hit1    = '0;
        for (int w = 0; w < NWAY; w++) begin
            if (fwd0_q[w]) rd_ohd0[w*ENTW +: ENTW] = fwd_ohd_q;
            if (fwd1_q[w]) rd_ohd1[w*ENTW +: ENTW] = fwd_ohd_q;
            hit0[w] = rd_ohd0[w*ENTW + TAGW] & (rd_ohd0[w*ENTW +: TAGW] == tag0_q);
            hit1[w] = rd_ohd1[w*ENTW + TAGW] & (rd_ohd1[w*ENTW +: TAGW] == tag1_q);
        end
    end

endmodule

// File: tb/tb_icache_overhead_banked.sv
// Randomised bench for icache_overhead_banked against a line/way array model.
module tb_icache_overhead_banked;

    localparam int LNUM   = 256;
    localparam int NWAY   = 2;
    localparam int TAGW   = 20;
    localparam int LADDRW = 8;
    localparam int WAYW   = 1;
    localparam int ENTW   = 1 + TAGW;
    localparam int OHDW   = NWAY * ENTW;
    localparam int SWEEP  = LNUM / 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              ready;
    logic              flush;
    logic              re;
    logic [LADDRW-1:0] rd_laddr;
    logic [TAGW-1:0]   rd_tag0, rd_tag1;
    logic              rd_valid;
    logic [OHDW-1:0]   rd_ohd0, rd_ohd1;
    logic [NWAY-1:0]   hit0, hit1;
    logic              we;
    logic [LADDRW-1:0] wr_laddr;
    logic [WAYW-1:0]   wr_way;
    logic [ENTW-1:0]   wr_ohd;

    icache_overhead_banked #(.LNUM(LNUM), .NWAY(NWAY), .TAGW(TAGW)) dut (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .flush   (flush),
        .re      (re),
        .rd_laddr(rd_laddr),
        .rd_tag0 (rd_tag0),
        .rd_tag1 (rd_tag1),
        .rd_valid(rd_valid),
        .rd_ohd0 (rd_ohd0),
        .rd_ohd1 (rd_ohd1),
        .hit0    (hit0),
        .hit1    (hit1),
        .we      (we),
        .wr_laddr(wr_laddr),
        .wr_way  (wr_way),
        .wr_ohd  (wr_ohd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: plain per-line/per-way contents, cycles of sweep left, expected outputs.
    logic [ENTW-1:0] m_mem [LNUM][NWAY];
    int              m_busy;
    logic            m_valid;
    logic [OHDW-1:0] m_ohd0, m_ohd1;
    logic [NWAY-1:0] m_hit0, m_hit1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int l = 0; l < LNUM; l++)
            for (int w = 0; w < NWAY; w++)
                m_mem[l][w] = '0;
    endtask

    task automatic m_line(input int l, input logic [TAGW-1:0] t,
                          output logic [OHDW-1:0] ohd, output logic [NWAY-1:0] hit);
        ohd = '0;
        hit = '0;
        for (int w = 0; w < NWAY; w++) begin
            ohd[w*ENTW +: ENTW] = m_mem[l][w];
            hit[w] = m_mem[l][w][TAGW] && (m_mem[l][w][TAGW-1:0] == t);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".ready"},    64'(ready),    64'(m_busy == 0));
        check({tag, ".rd_valid"}, 64'(rd_valid), 64'(m_valid));
        check({tag, ".rd_ohd0"},  64'(rd_ohd0),  64'(m_ohd0));
        check({tag, ".rd_ohd1"},  64'(rd_ohd1),  64'(m_ohd1));
        check({tag, ".hit0"},     64'(hit0),     64'(m_hit0));
        check({tag, ".hit1"},     64'(hit1),     64'(m_hit1));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic tick(input bit re_v, input int ra, input logic [TAGW-1:0] t0, input logic [TAGW-1:0] t1,
                        input bit we_v, input int wa, input int ww, input logic [ENTW-1:0] wo,
                        input bit fl, input string tag);
        re       = re_v;
        rd_laddr = LADDRW'(ra);
        rd_tag0  = t0;
        rd_tag1  = t1;
        we       = we_v;
        wr_laddr = LADDRW'(wa);
        wr_way   = WAYW'(ww);
        wr_ohd   = wo;
        flush    = fl;
        if (m_busy > 0) begin
            m_busy--;
            m_valid = 1'b0;
        end else if (fl) begin
            m_clear();
            m_busy  = SWEEP;
            m_valid = 1'b0;
        end else begin
            if (we_v) m_mem[wa % LNUM][ww] = wo;
            m_valid = re_v;
            if (re_v) begin
                m_line(ra % LNUM, t0, m_ohd0, m_hit0);
                m_line((ra + 1) % LNUM, t1, m_ohd1, m_hit1);
            end
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        tick(0, 0, '0, '0, 0, 0, 0, '0, 0, tag);
    endtask

    task automatic rand_tick(input bit allow_flush, input string tag);
        int ra, wa;
        ra = (($urandom_range(0, 1) != 0) ? 248 : 0) + int'($urandom_range(0, 15));
        wa = (($urandom_range(0, 1) != 0) ? 248 : 0) + int'($urandom_range(0, 15));
        tick($urandom_range(0, 9) < 7, ra % LNUM,
             TAGW'($urandom_range(0, 3)), TAGW'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, wa % LNUM, int'($urandom_range(0, NWAY - 1)),
             {1'($urandom_range(0, 3) != 0), TAGW'($urandom_range(0, 3))},
             allow_flush && ($urandom_range(0, 199) == 0), tag);
    endtask

    // Count ticks until ready rises; optionally re-pulse flush part way through.
    task automatic count_sweep(input string tag, input int reflush_at);
        int n;
        n = 0;
        while (n < 300) begin
            tick(1, int'($urandom_range(0, LNUM - 1)), '0, '0,
                 1, int'($urandom_range(0, LNUM - 1)), 0, {1'b1, TAGW'(1)},
                 n == reflush_at, tag);
            n++;
            if (ready === 1'b1) break;
        end
        check({tag, ".len"}, 64'(n), 64'(SWEEP));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        m_clear();
        m_busy  = SWEEP;
        m_valid = 1'b0;
        m_ohd0  = '0;
        m_ohd1  = '0;
        m_hit0  = '0;
        m_hit1  = '0;
        compare_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {flush, re, we} = '0;
        rd_laddr = '0; rd_tag0 = '0; rd_tag1 = '0;
        wr_laddr = '0; wr_way = '0; wr_ohd = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        count_sweep("init_sweep", -1);
        for (int i = 0; i < 20; i++) rand_tick(0, "after_sweep");

        tick(0, 0, '0, '0, 1, 5, 1, {1'b1, TAGW'('hABCDE)}, 0, "pair_w0");
        tick(0, 0, '0, '0, 1, 6, 0, {1'b1, TAGW'('h12345)}, 0, "pair_w1");
        tick(1, 5, TAGW'('hABCDE), TAGW'('h12345), 0, 0, 0, '0, 0, "pair_rd");
        check("pair.hit0", 64'(hit0), 64'(2'b10));
        check("pair.hit1", 64'(hit1), 64'(2'b01));

        tick(0, 0, '0, '0, 1, 255, 0, {1'b1, TAGW'(1)}, 0, "wrap_w0");
        tick(0, 0, '0, '0, 1, 0, 1, {1'b1, TAGW'(2)}, 0, "wrap_w1");
        tick(1, 255, TAGW'(1), TAGW'(2), 0, 0, 0, '0, 0, "wrap_rd");
        check("wrap.hit0", 64'(hit0), 64'(2'b01));
        check("wrap.hit1", 64'(hit1), 64'(2'b10));

        tick(1, 6, '0, TAGW'('h77), 1, 7, 0, {1'b1, TAGW'('h77)}, 0, "fwd");
        check("fwd.hit1_0", 64'(hit1[0]), 64'(1'b1));
        idle("hold");
        check("hold.hit1_0", 64'(hit1[0]), 64'(1'b1));
        tick(1, 255, '0, TAGW'('h55), 1, 0, 0, {1'b1, TAGW'('h55)}, 0, "fwd_wrap");
        check("fwd_wrap.hit1_0", 64'(hit1[0]), 64'(1'b1));

        for (int i = 0; i < 800; i++) rand_tick(1, "rand");
        while (m_busy > 0) rand_tick(0, "drain");

        for (int i = 0; i < 10; i++)
            tick(0, 0, '0, '0, 1, 20 + i, i % NWAY, {1'b1, TAGW'(20 + i)}, 0, "populate");
        tick(0, 0, '0, '0, 1, 9, 0, {1'b1, TAGW'('h99)}, 1, "flush_we");
        count_sweep("flush_sweep", 50);
        tick(1, 9, TAGW'('h99), '0, 0, 0, 0, '0, 0, "flush_rd9");
        check("flush.hit0", 64'(hit0), 64'(0));
        tick(1, 20, TAGW'(20), TAGW'(21), 0, 0, 0, '0, 0, "flush_rd20");
        check("flush.hit1", 64'(hit1), 64'(0));

        tick(0, 0, '0, '0, 0, 0, 0, '0, 1, "flush_pre_rst");
        for (int i = 0; i < 40; i++) rand_tick(0, "mid_sweep");
        do_reset();
        count_sweep("rst_sweep", -1);
        for (int i = 0; i < 50; i++) rand_tick(0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache_overhead_banked.md
Name: icache_overhead_banked

Overview:
- Parametrised successor of the I-cache overhead (valid+tag) store. Lines are split into even/odd banks, so any two consecutive lines (laddr, laddr+1) are always readable in one access, including the wrap from the last line to line 0. No spare row is needed.
- Generalised to NWAY ways and configurable tag width.
- Adds a hardware invalidate sweep (after reset and on flush), same-cycle write forwarding, and per-way hit compare.
- Sits between the fetch stage (dual-line lookup) and the refill FSM (single-line writes).

Parameters:
- LNUM, 256: lines per way; power of two, ≥4.
- NWAY, 2: associativity, ≥1.
- TAGW, 20: tag width.
- LADDRW, $clog2(LNUM): line-index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ready  out  1  block accepting reads/writes (low during sweep)
- flush  in  1  request invalidation of all lines in all ways
- re  in  1  lookup request
- rd_laddr  in  LADDRW  first line index; second line = rd_laddr+1 mod LNUM
- rd_tag0  in  TAGW  tag compared against line rd_laddr
- rd_tag1  in  TAGW  tag compared against line rd_laddr+1
- rd_valid  out  1  lookup result valid
- rd_ohd0  out  NWAY*(1+TAGW)  {valid,tag} per way for line rd_laddr; way 0 in the LSBs
- rd_ohd1  out  NWAY*(1+TAGW)  same for line rd_laddr+1
- hit0  out  NWAY  per-way hit, line rd_laddr
- hit1  out  NWAY  per-way hit, line rd_laddr+1
- we  in  1  write one line/way
- wr_laddr  in  LADDRW  line index to write
- wr_way  in  $clog2(NWAY) (min 1)  way to write
- wr_ohd  in  1+TAGW  {valid,tag} to write

Behaviour:
- Storage:
  - Bank E holds even lines, bank O holds odd lines. Row = laddr>>1. Each bank row holds NWAY entries.
  - Line L maps to bank L[0], row L>>1.
  - Second line of a lookup: if rd_laddr[0]=0, the same row in bank O; else row+1 in bank E.
  - Row+1 wraps to 0 at row LNUM/2-1 (line LNUM-1 pairs with line 0).
- FSM states: CLEAR, RUN.
  - rst asserted → CLEAR, row counter=0, ready=0, rd_valid=0, rd_ohd*/hit*=0.
  - CLEAR: each cycle writes valid=0, tag=0 to row counter in both banks, all ways, then increments the counter.
    - After the row LNUM/2-1 write, go to RUN the next cycle.
    - Sweep lasts exactly LNUM/2 cycles; ready=1 from the first RUN cycle.
  - RUN with flush=1 → CLEAR, counter=0, ready=0 the next cycle. A re/we in the same cycle as flush is dropped.
  - flush during CLEAR is ignored; the sweep continues without restarting.
  - re/we while ready=0 are dropped and have no effect; rd_valid stays 0.
  - rst asserted mid-sweep restarts the sweep from row 0.
- Lookup:
  - Latency 1: re accepted in cycle N → rd_valid=1, rd_ohd0/1 and hit0/1 valid in N+1.
  - rd_valid is a 1-cycle pulse per accepted re; back-to-back lookups are allowed every cycle.
  - Data registers hold their last value when re=0; only rd_valid drops.
  - hit*[w] = entry.valid & (entry.tag == registered rd_tag*). Computed combinationally from output registers and the registered tags.
- Write:
  - Takes effect at the clock edge; visible to lookups accepted in the next cycle.
- Simultaneous re and we:
  - Write-first forwarding. If the written line/way matches either looked-up line, the corresponding rd_ohd field and hit reflect wr_ohd.
  - Applies to both lines, including the wrap pair.
- Arithmetic: row increment is modulo LNUM/2; the line-address compare is exact LADDRW bits.

Decomposition:
- icache_pkg adds: default constants ICACHE_LNUM, ICACHE_NWAY, ICACHE_TAGW; typedef ohd_entry_t {logic valid; logic [TAGW-1:0] tag} using the package defaults; enum clr_state_t {CLEAR, RUN}.
- The module uses flat vectors internally so parameter overrides work.
- One sub-module, icache_ohd_bank: single bank, LNUM/2 rows × NWAY entries. Provides a registered read port, a write port with a per-way enable, and a whole-row clear enable. Instantiated twice (E/O); intended to infer BRAM.

Test Plan:
- Reset sweep: release rst, LNUM=256 → ready=0 for exactly 128 cycles, then 1. Every subsequent lookup returns valid=0 and hit=0 in all ways.
- Boundary pair: write line 5 way1 {1,0xABCDE}, line 6 way0 {1,0x12345}. Lookup rd_laddr=5, tags 0xABCDE/0x12345 → next cycle hit0=2'b10, hit1=2'b01.
- Wrap: write line 255 way0 {1,0x1}, line 0 way1 {1,0x2}. Lookup rd_laddr=255, tags 0x1/0x2 → hit0=2'b01, hit1=2'b10.
- Forwarding: same cycle re rd_laddr=6 with we line 7 way0 {1,0x77}, rd_tag1=0x77 → hit1[0]=1 in the next cycle.
- Flush: populate lines, pulse flush with a concurrent we → ready low 128 cycles, write dropped, all hits 0 afterward. A second flush mid-sweep does not extend the 128 cycles.
- Async reset mid-sweep at cycle 40 → ready stays 0 for 128 cycles after rst deasserts; rd_valid=0 throughout.
